// File: rtl/cpu_params_pkg.sv
// Shared CPU parameters: register width, MMR window layout and responder FSM states.
package cpu_params_pkg;

   localparam int RSZ = 32;

   // The window spans 32 bytes, which is eight word slots.
   localparam int MMR_WIN_BYTES = 32;

   localparam logic [4:0] MMR_MTIME_LO    = 5'h00;
   localparam logic [4:0] MMR_MTIME_HI    = 5'h04;
   localparam logic [4:0] MMR_MTIMECMP_LO = 5'h08;
   localparam logic [4:0] MMR_MTIMECMP_HI = 5'h0C;
   localparam logic [4:0] MMR_MSIP        = 5'h10;

   // Bit positions in the one-hot register select.
   localparam int SEL_MTIME_LO    = 0;
   localparam int SEL_MTIME_HI    = 1;
   localparam int SEL_MTIMECMP_LO = 2;
   localparam int SEL_MTIMECMP_HI = 3;
   localparam int SEL_MSIP        = 4;
   localparam int SEL_W           = 5;

   typedef enum logic {
      IDLE = 1'b0,
      RESP = 1'b1
   } mmr_state_t;

endpackage

// File: rtl/mmr_ctrl_decode.sv
// mmr_decode: combinational offset/legality decoder for the timer MMR window.
// Produces a one-hot register select and a fault flag; kept separate so a
// future debug-port responder can share it.
module mmr_decode
   import cpu_params_pkg::*;
(
   input  logic [4:0]       offset,
   input  logic [3:0]       be,
   output logic [SEL_W-1:0] sel,
   output logic             err
);

   // Word-slot decode, then fault on misalignment, partial enables or reserved slot.
   always_comb begin
      sel = '0;
      case ({offset[4:2], 2'b00})
         MMR_MTIME_LO:    sel[SEL_MTIME_LO]    = 1'b1;
         MMR_MTIME_HI:    sel[SEL_MTIME_HI]    = 1'b1;
         MMR_MTIMECMP_LO: sel[SEL_MTIMECMP_LO] = 1'b1;
         MMR_MTIMECMP_HI: sel[SEL_MTIMECMP_HI] = 1'b1;
         MMR_MSIP:        sel[SEL_MSIP]        = 1'b1;
         default:         sel = '0;
      endcase
      err = (offset[1:0] != 2'b00) || (be != 4'hF) || (sel == '0);
   end

endmodule

// File: rtl/mmr_ctrl.sv
// mmr_ctrl: bus responder for the timer / software-interrupt MMR window.
// One access per two cycles: request sampled in IDLE, ack pulsed from RESP.
// Optional build macro MMR_SNAPSHOT_EN adds an mtime_hi shadow so that a
// lo-then-hi read pair returns a coherent 64-bit time.
//
//   state | meaning
//   IDLE  | waiting for an in-window request
//   RESP  | ack/err/rd_data/strobe valid for this single cycle
module mmr_ctrl
   import cpu_params_pkg::*;
#(
   parameter logic [31:0] MMR_BASE = 32'hFFFF_FF00
) (
   input  logic             clk_in,
   input  logic             reset_in,
   input  logic             req,
   input  logic             req_wr,
   input  logic [31:0]      req_addr,
   input  logic [3:0]       req_be,
   input  logic [RSZ-1:0]   req_wr_data,
   output logic             ack,
   output logic             err,
   output logic [RSZ-1:0]   rd_data,
   output logic             in_range,
   output logic             mtime_lo_wr,
   output logic             mtime_hi_wr,
   output logic             mtimecmp_lo_wr,
   output logic             mtimecmp_hi_wr,
   output logic             msip_wr,
   output logic [RSZ-1:0]   mmr_wr_data,
   input  logic [RSZ*2-1:0] mtime,
   input  logic [RSZ*2-1:0] mtimecmp,
   input  logic             sw_irq
);

   mmr_state_t       state;
   logic [SEL_W-1:0] sel;
   logic             dec_err;
   logic [SEL_W-1:0] wr_stb;
   logic [RSZ-1:0]   rd_mux;
   logic [RSZ-1:0]   mtime_hi_rd;
   logic             take;

   // Base is 32-byte aligned, so the window offset is just the low address bits.
   assign in_range = (req_addr[31:5] == MMR_BASE[31:5]);
   assign take     = (state == IDLE) && req && in_range;

   mmr_decode u_decode (
      .offset (req_addr[4:0]),
      .be     (req_be),
      .sel    (sel),
      .err    (dec_err)
   );

`ifdef MMR_SNAPSHOT_EN
   logic [RSZ-1:0] shadow;
   logic           shadow_vld;

   assign mtime_hi_rd = shadow_vld ? shadow : mtime[RSZ*2-1:RSZ];

   // Latch mtime_hi on a legal mtime_lo read; consume on hi read or invalidate on time writes.
   always_ff @(posedge clk_in) begin
      if (reset_in) begin
         shadow     <= '0;
         shadow_vld <= 1'b0;
      end else if (take && !dec_err) begin
         if (!req_wr && sel[SEL_MTIME_LO]) begin
            shadow     <= mtime[RSZ*2-1:RSZ];
            shadow_vld <= 1'b1;
         end else if (!req_wr && sel[SEL_MTIME_HI]) begin
            shadow_vld <= 1'b0;
         end else if (req_wr && (sel[SEL_MTIME_LO] || sel[SEL_MTIME_HI])) begin
            shadow_vld <= 1'b0;
         end
      end
   end
`else
   assign mtime_hi_rd = mtime[RSZ*2-1:RSZ];
`endif

   // Read data selection for the addressed register.
   always_comb begin
      rd_mux = '0;
      if (sel[SEL_MTIME_LO])         rd_mux = mtime[RSZ-1:0];
      else if (sel[SEL_MTIME_HI])    rd_mux = mtime_hi_rd;
      else if (sel[SEL_MTIMECMP_LO]) rd_mux = mtimecmp[RSZ-1:0];
      else if (sel[SEL_MTIMECMP_HI]) rd_mux = mtimecmp[RSZ*2-1:RSZ];
      else if (sel[SEL_MSIP])        rd_mux = {{(RSZ-4){1'b0}}, sw_irq, 3'b000};
   end

   // Responder FSM; all bus-facing outputs are registered and live for RESP only.
   always_ff @(posedge clk_in) begin
      if (reset_in) begin
         state       <= IDLE;
         ack         <= 1'b0;
         err         <= 1'b0;
         rd_data     <= '0;
         wr_stb      <= '0;
         mmr_wr_data <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (take) begin
                  state       <= RESP;
                  ack         <= 1'b1;
                  err         <= dec_err;
                  wr_stb      <= (req_wr && !dec_err) ? sel : '0;
                  mmr_wr_data <= (req_wr && !dec_err) ? req_wr_data : '0;
                  rd_data     <= (!req_wr && !dec_err) ? rd_mux : '0;
               end
            end
            RESP: begin
               state       <= IDLE;
               ack         <= 1'b0;
               err         <= 1'b0;
               rd_data     <= '0;
               wr_stb      <= '0;
               mmr_wr_data <= '0;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign mtime_lo_wr    = wr_stb[SEL_MTIME_LO];
   assign mtime_hi_wr    = wr_stb[SEL_MTIME_HI];
   assign mtimecmp_lo_wr = wr_stb[SEL_MTIMECMP_LO];
   assign mtimecmp_hi_wr = wr_stb[SEL_MTIMECMP_HI];
   assign msip_wr        = wr_stb[SEL_MSIP];

endmodule

// File: tb/tb_mmr_ctrl.sv
// tb_mmr_ctrl: directed-vector bench for mmr_ctrl with a minimal irq register model.
module tb_mmr_ctrl;
   import cpu_params_pkg::*;

   logic             clk_in = 1'b0;
   logic             reset_in;
   logic             req;
   logic             req_wr;
   logic [31:0]      req_addr;
   logic [3:0]       req_be;
   logic [RSZ-1:0]   req_wr_data;
   logic             ack;
   logic             err;
   logic [RSZ-1:0]   rd_data;
   logic             in_range;
   logic             mtime_lo_wr;
   logic             mtime_hi_wr;
   logic             mtimecmp_lo_wr;
   logic             mtimecmp_hi_wr;
   logic             msip_wr;
   logic [RSZ-1:0]   mmr_wr_data;
   logic [RSZ*2-1:0] mtime;
   logic [RSZ*2-1:0] mtimecmp_m = '0;
   logic             sw_irq_m   = 1'b0;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk_in = ~clk_in;

   mmr_ctrl #(.MMR_BASE(32'hFFFF_FF00)) dut (
      .clk_in         (clk_in),
      .reset_in       (reset_in),
      .req            (req),
      .req_wr         (req_wr),
      .req_addr       (req_addr),
      .req_be         (req_be),
      .req_wr_data    (req_wr_data),
      .ack            (ack),
      .err            (err),
      .rd_data        (rd_data),
      .in_range       (in_range),
      .mtime_lo_wr    (mtime_lo_wr),
      .mtime_hi_wr    (mtime_hi_wr),
      .mtimecmp_lo_wr (mtimecmp_lo_wr),
      .mtimecmp_hi_wr (mtimecmp_hi_wr),
      .msip_wr        (msip_wr),
      .mmr_wr_data    (mmr_wr_data),
      .mtime          (mtime),
      .mtimecmp       (mtimecmp_m),
      .sw_irq         (sw_irq_m)
   );

   // Stand-in for the irq block: takes the write strobes on the next edge.
   always @(posedge clk_in) begin
      if (mtimecmp_lo_wr) mtimecmp_m[31:0]  <= mmr_wr_data;
      if (mtimecmp_hi_wr) mtimecmp_m[63:32] <= mmr_wr_data;
      if (msip_wr)        sw_irq_m          <= mmr_wr_data[3];
   end

   function automatic logic [4:0] stb();
      return {mtime_lo_wr, mtime_hi_wr, mtimecmp_lo_wr, mtimecmp_hi_wr, msip_wr};
   endfunction

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   // Present a request before edge n; return at the negedge of cycle n+1.
   task automatic issue(input logic wr, input logic [31:0] addr, input logic [3:0] be,
                        input logic [31:0] data);
      @(negedge clk_in);
      req         = 1'b1;
      req_wr      = wr;
      req_addr    = addr;
      req_be      = be;
      req_wr_data = data;
      @(negedge clk_in);
   endtask

   task automatic release_req();
      req = 1'b0;
      @(negedge clk_in);
   endtask

   initial begin
      logic [31:0] exp_hi;
      reset_in    = 1'b1;
      req         = 1'b0;
      req_wr      = 1'b0;
      req_addr    = '0;
      req_be      = '0;
      req_wr_data = '0;
      mtime       = '0;
      repeat (2) @(negedge clk_in);
      check_val("rst_ack",   ack,     0);
      check_val("rst_err",   err,     0);
      check_val("rst_rd",    rd_data, 0);
      check_val("rst_stb",   stb(),   0);
      check_val("rst_wdata", mmr_wr_data, 0);
      reset_in = 1'b0;
      @(negedge clk_in);
      check_val("idle_ack", ack, 0);

      // legal store to mtimecmp_lo
      issue(1'b1, 32'hFFFF_FF08, 4'hF, 32'h0000_1000);
      check_val("wr_inrange", in_range, 1);
      check_val("wr_ack",   ack,   1);
      check_val("wr_err",   err,   0);
      check_val("wr_stb",   stb(), 5'b00100);
      check_val("wr_data",  mmr_wr_data, 32'h1000);
      release_req();
      check_val("wr_ack_drop", ack, 0);
      check_val("wr_stb_drop", stb(), 0);
      check_val("wr_data_drop", mmr_wr_data, 0);
      check_val("irq_cmp_lo", mtimecmp_m[31:0], 32'h1000);

      // legal load of mtime_hi
      mtime = 64'h0000_0002_FFFF_FFF0;
      issue(1'b0, 32'hFFFF_FF04, 4'hF, 32'h0);
      check_val("rd_ack", ack,     1);
      check_val("rd_err", err,     0);
      check_val("rd_hi",  rd_data, 32'h0000_0002);
      check_val("rd_stb", stb(),   0);
      release_req();
      check_val("rd_hold0", rd_data, 0);

      // mtimecmp_lo read back through the irq model
      issue(1'b0, 32'hFFFF_FF08, 4'hF, 32'h0);
      check_val("rd_cmp_lo", rd_data, 32'h1000);
      release_req();

      // faults
      issue(1'b1, 32'hFFFF_FF02, 4'hF, 32'hDEAD_BEEF);
      check_val("mis_ack", ack, 1);
      check_val("mis_err", err, 1);
      check_val("mis_stb", stb(), 0);
      check_val("mis_wdata", mmr_wr_data, 0);
      release_req();
      issue(1'b1, 32'hFFFF_FF08, 4'h3, 32'h0000_5555);
      check_val("be_err", err, 1);
      check_val("be_stb", stb(), 0);
      release_req();
      check_val("be_cmp_kept", mtimecmp_m[31:0], 32'h1000);
      issue(1'b0, 32'hFFFF_FF18, 4'hF, 32'h0);
      check_val("rsv_ack", ack, 1);
      check_val("rsv_err", err, 1);
      check_val("rsv_rd",  rd_data, 0);
      release_req();

      // outside the window: ignored
      issue(1'b0, 32'hFFFF_FE00, 4'hF, 32'h0);
      check_val("oor_inrange", in_range, 0);
      check_val("oor_ack", ack, 0);
      @(negedge clk_in);
      check_val("oor_ack2", ack, 0);
      release_req();

      // lo/hi coherency
      mtime = 64'h0000_0001_FFFF_FFFF;
      issue(1'b0, 32'hFFFF_FF00, 4'hF, 32'h0);
      check_val("coh_lo", rd_data, 32'hFFFF_FFFF);
      release_req();
      mtime = 64'h0000_0002_0000_0000;
      issue(1'b0, 32'hFFFF_FF04, 4'hF, 32'h0);
`ifdef MMR_SNAPSHOT_EN
      exp_hi = 32'h0000_0001;
`else
      exp_hi = 32'h0000_0002;
`endif
      check_val("coh_hi", rd_data, {32'h0, exp_hi});
      release_req();
      // second hi read is always live
      mtime = 64'h0000_0003_0000_0000;
      issue(1'b0, 32'hFFFF_FF04, 4'hF, 32'h0);
      check_val("coh_hi_live", rd_data, 32'h0000_0003);
      release_req();

      // back-to-back held request: msip write then msip read
      issue(1'b1, 32'hFFFF_FF10, 4'hF, 32'h0000_0008);
      check_val("b2b_ack1", ack, 1);
      check_val("b2b_msip", stb(), 5'b00001);
      req_wr = 1'b0;
      @(negedge clk_in);
      check_val("b2b_gap", ack, 0);
      @(negedge clk_in);
      check_val("b2b_ack2", ack, 1);
      check_val("b2b_rd",   rd_data, 32'h8);
      check_val("b2b_err",  err, 0);
      release_req();

      // reset while in RESP
      issue(1'b1, 32'hFFFF_FF0C, 4'hF, 32'h0000_00AA);
      check_val("rr_ack", ack, 1);
      reset_in = 1'b1;
      req      = 1'b0;
      @(negedge clk_in);
      check_val("rr_ack0", ack, 0);
      check_val("rr_stb0", stb(), 0);
      reset_in = 1'b0;
      @(negedge clk_in);
      check_val("rr_ack_idle", ack, 0);
      check_val("rr_rd_idle", rd_data, 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

endmodule
